// File: rtl/dot_accumulator.sv
// Accumulates signed products into VEC_LEN-element dot products; one-cycle result pulse.
// Optional clamping on signed overflow with `define DOT_ACC_SATURATE_EN (default: wrap-around).
module dot_accumulator #(
    parameter int P_WIDTH   = 14,
    parameter int ACC_WIDTH = 20,
    parameter int VEC_LEN   = 4,
    localparam int CNT_WIDTH = $clog2(VEC_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic signed [P_WIDTH-1:0]   in_P,
    input  logic                        in_flush,
    output logic                        out_valid,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0]        out_count,
    output logic                        out_ovf
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]        cnt;
    logic                        ovf_sticky;

    logic signed [ACC_WIDTH-1:0] p_ext;
    logic signed [ACC_WIDTH-1:0] raw_sum;
    logic signed [ACC_WIDTH-1:0] next_acc;
    logic [CNT_WIDTH-1:0]        cnt_inc;
    logic                        ovf_this;
    logic                        last_slot;
    logic                        close_vec;

    if (ACC_WIDTH > P_WIDTH) begin : g_ext
        assign p_ext = {{(ACC_WIDTH - P_WIDTH){in_P[P_WIDTH-1]}}, in_P};
    end else begin : g_noext
        assign p_ext = in_P;
    end

    assign raw_sum  = acc + p_ext;
    assign ovf_this = in_valid && (acc[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1])
                               && (raw_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

    always_comb begin
        next_acc = acc;
        if (in_valid) begin
            next_acc = raw_sum;
`ifdef DOT_ACC_SATURATE_EN
            // Both operands share acc's sign when overflow occurs, so acc's sign picks the rail.
            if (ovf_this) begin
                next_acc = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                            : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
`endif
        end
    end

    assign cnt_inc   = cnt + {{(CNT_WIDTH-1){1'b0}}, in_valid};
    assign last_slot = (cnt == CNT_WIDTH'(VEC_LEN - 1));
    // A flush only closes a vector that holds at least one product, so empty vectors never emit.
    assign close_vec = (in_valid && last_slot) || (in_flush && (cnt_inc != '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else begin
            out_valid <= close_vec;
            if (close_vec) begin
                out_sum    <= next_acc;
                out_count  <= cnt_inc;
                out_ovf    <= ovf_sticky | ovf_this;
                acc        <= '0;
                cnt        <= '0;
                ovf_sticky <= 1'b0;
            end else if (in_valid) begin
                acc        <= next_acc;
                cnt        <= cnt_inc;
                ovf_sticky <= ovf_sticky | ovf_this;
            end
        end
    end

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: default build plus a 14-bit accumulator instance for overflow.
module tb_dot_accumulator;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic signed [13:0] in_P;
    logic              in_flush;

    logic              out_valid;
    logic signed [19:0] out_sum;
    logic [2:0]        out_count;
    logic              out_ovf;

    logic              o_valid;
    logic signed [13:0] o_sum;
    logic [2:0]        o_count;
    logic              o_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    dot_accumulator dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_P(in_P), .in_flush(in_flush),
        .out_valid(out_valid), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    dot_accumulator #(.P_WIDTH(14), .ACC_WIDTH(14), .VEC_LEN(4)) dut_o (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_P(in_P), .in_flush(in_flush),
        .out_valid(o_valid), .out_sum(o_sum), .out_count(o_count), .out_ovf(o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic v;
        int   p;
        logic f;
        logic ev;
        int   es;
        int   ec;
        logic eo;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input int p, input logic f,
                                input logic ev, input int es, input int ec);
        vec_t r;
        r.v = v; r.p = p; r.f = f; r.ev = ev; r.es = es; r.ec = ec; r.eo = 1'b0;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic step(input logic v, input int p, input logic f);
        @(negedge clk);
        in_valid = v;
        in_P     = 14'(p);
        in_flush = f;
        @(posedge clk);
        #1;
    endtask

    int last_sum, last_cnt, last_ovf;
    int exp_o_sum;

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_P = '0; in_flush = 1'b0;
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_sum",   int'(out_sum),   0);
        chk("reset out_count", int'(out_count), 0);
        chk("reset out_ovf",   int'(out_ovf),   0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Full vector of -6
        add(1, -6, 0, 0, 0, 0); add(1, -6, 0, 0, 0, 0); add(1, -6, 0, 0, 0, 0);
        add(1, -6, 0, 1, -24, 4);
        // Gapped input
        add(1, 5, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0); add(1, -3, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0); add(1, 10, 0, 0, 0, 0);
        add(1, 1, 0, 1, 13, 4);
        // Flush with product, then flush on empty vector
        add(1, 7, 0, 0, 0, 0); add(1, -2, 0, 0, 0, 0); add(1, 4, 1, 1, 9, 3);
        add(0, 0, 1, 0, 0, 0);
        // Flush without product after one element; flush+product on an empty vector
        add(1, 3, 0, 0, 0, 0); add(0, 0, 1, 1, 3, 1);
        add(1, 2, 1, 1, 2, 1);
        add(0, 0, 0, 0, 0, 0);
        // Back-to-back: eight ones
        for (int k = 0; k < 8; k++) add(1, 1, 0, (k % 4 == 3), 4, 4);
        add(0, 0, 0, 0, 0, 0);

        last_sum = 0; last_cnt = 0; last_ovf = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].p, tbl[i].f);
            if (tbl[i].ev) begin
                last_sum = tbl[i].es; last_cnt = tbl[i].ec; last_ovf = int'(tbl[i].eo);
            end
            chk($sformatf("row%0d out_valid", i), int'(out_valid), int'(tbl[i].ev));
            chk($sformatf("row%0d o_valid", i),   int'(o_valid),   int'(tbl[i].ev));
            chk($sformatf("row%0d out_sum", i),   int'(out_sum),   last_sum);
            chk($sformatf("row%0d out_count", i), int'(out_count), last_cnt);
            chk($sformatf("row%0d out_ovf", i),   int'(out_ovf),   last_ovf);
        end

        // Positive overflow in the 14-bit instance
        for (int k = 0; k < 4; k++) step(1, 4096, 0);
        step(0, 0, 0);
`ifdef DOT_ACC_SATURATE_EN
        exp_o_sum = 8191;
`else
        exp_o_sum = 0;
`endif
        chk("pos ovf o_sum",     int'(o_sum),     exp_o_sum);
        chk("pos ovf o_ovf",     int'(o_ovf),     1);
        chk("pos ovf o_count",   int'(o_count),   4);
        chk("pos ovf out_sum",   int'(out_sum),   16384);
        chk("pos ovf out_ovf",   int'(out_ovf),   0);

        // Negative overflow in the 14-bit instance
        for (int k = 0; k < 4; k++) step(1, -8192, 0);
        chk("neg ovf o_valid",   int'(o_valid),   1);
`ifdef DOT_ACC_SATURATE_EN
        exp_o_sum = -8192;
`else
        exp_o_sum = 0;
`endif
        chk("neg ovf o_sum",     int'(o_sum),     exp_o_sum);
        chk("neg ovf o_ovf",     int'(o_ovf),     1);
        chk("neg ovf out_sum",   int'(out_sum),   -32768);
        step(0, 0, 0);
        chk("ovf sticky cleared", int'(o_valid),  0);

        // Reset mid-vector, asserted between edges
        step(1, 100, 0);
        step(1, 100, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst out_valid",  int'(out_valid), 0);
        chk("midrst out_sum",    int'(out_sum),   0);
        chk("midrst out_count",  int'(out_count), 0);
        chk("midrst o_sum",      int'(o_sum),     0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0);
            chk($sformatf("postrst nopulse%0d", k), int'(out_valid), 0);
        end
        step(1, 1, 0);
        chk("postrst out_valid", int'(out_valid), 1);
        chk("postrst out_sum",   int'(out_sum),   4);
        chk("postrst out_count", int'(out_count), 4);
        chk("postrst out_ovf",   int'(out_ovf),   0);
        step(0, 0, 0);
        chk("postrst pulse width", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dot_accumulator.md
Name: dot_accumulator

Overview:
- Downstream consumer of the signed multiplier stage (in_valid/in_P fed straight from its out_valid/out_C).
- Accumulates a stream of signed products into VEC_LEN-element dot-product sums.
- Emits each sum with a one-cycle valid pulse, element count and overflow flag.
- Supports early flush for short vectors.
- No backpressure: the multiplier has none, so every valid product is consumed on the cycle it arrives.

Parameters:
P_WIDTH, 14, width of signed input product (A_WIDTH+B_WIDTH of upstream multiplier)
ACC_WIDTH, 20, width of signed accumulator and out_sum; must be >= P_WIDTH
VEC_LEN, 4, number of products per dot product; must be >= 2
CNT_WIDTH, $clog2(VEC_LEN+1), width of out_count (derived localparam, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  in_P holds a product this cycle
in_P  input  P_WIDTH  signed product from multiplier
in_flush  input  1  close current vector early
out_valid  output  1  one-cycle pulse, out_sum/out_count/out_ovf valid
out_sum  output  ACC_WIDTH  signed dot-product result
out_count  output  CNT_WIDTH  number of products in the emitted sum (1..VEC_LEN)
out_ovf  output  1  signed overflow occurred at least once in this vector

Behaviour:
- Reset (reset=0, async): acc=0, cnt=0, ovf_sticky=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. Held while reset=0. Release is synchronous to clk: first update on the first rising edge with reset=1.
- in_P is sign-extended to ACC_WIDTH before addition.
- next = acc + sext(in_P) when in_valid=1, else acc.
- ovf_this = in_valid & (sign(acc)==sign(sext(in_P))) & (sign(sum)!=sign(acc)).
- Accumulate: in_valid=1, cnt<VEC_LEN-1, in_flush=0 -> acc<=next, cnt<=cnt+1, ovf_sticky|=ovf_this, out_valid<=0.
- Close: (in_valid=1 and cnt==VEC_LEN-1) OR (in_flush=1 and cnt+in_valid>=1). On the same edge:
  - out_sum<=next, out_count<=cnt+in_valid, out_ovf<=ovf_sticky|ovf_this, out_valid<=1;
  - acc<=0, cnt<=0, ovf_sticky<=0.
- Latency: out_valid rises on the clock edge after the cycle carrying the closing product or flush.
- in_flush with cnt==0 and in_valid=0: no-op, no output (empty vectors never emitted).
- in_flush together with in_valid: the product is included in the emitted sum.
- in_valid=0 and in_flush=0: all state holds; out_valid<=0.
- out_sum/out_count/out_ovf hold their last value between pulses. out_valid is high for exactly one cycle per vector.
- Back-to-back vectors: a product arriving the cycle after a close starts the new vector at cnt=0 with no bubble. Sustained throughput is one product per clock.
- Reset mid-vector discards the partial acc. No out_valid is produced for the discarded vector.

Optional Feature:
DOT_ACC_SATURATE_EN
- Defined: when ovf_this=1, the result is clamped to +max (2^(ACC_WIDTH-1)-1) if the operands were positive, or -min (-2^(ACC_WIDTH-1)) if negative. The clamp applies to both the acc update and out_sum. Accumulation continues from the clamped value. out_ovf is still reported.
- Not defined: two's-complement wrap-around. out_ovf is reported identically.

Test Plan:
- Full vector: reset; in_P=-6 (3*-2) valid for 4 consecutive cycles -> one pulse, out_sum=-24, out_count=4, out_ovf=0, exactly 1 cycle after 4th product.
- Gapped input: products 5,_,-3,_,_,10,1 (_ = in_valid low) -> single pulse after the 1 with out_sum=13, out_count=4; no pulse earlier.
- Flush: products 7,-2, then in_flush=1 with in_valid=1 and in_P=4 -> out_sum=9, out_count=3. Next cycle in_flush alone with cnt=0 -> no pulse.
- Back-to-back: 8 consecutive products of value 1 -> two pulses exactly 4 cycles apart, each out_sum=4.
- Overflow (ACC_WIDTH=14): four products of 4096 -> without macro: out_sum=0 (wrapped), out_ovf=1. With DOT_ACC_SATURATE_EN: out_sum=8191, out_ovf=1.
- Reset mid-vector: two products of 100, assert reset=0 asynchronously between edges -> all outputs 0 immediately. After release, four products of 1 -> out_sum=4, out_count=4.
